dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
Data-memory responder for the Mem stage's load/store requests. It accepts one request at a time over a valid/ready handshake and applies byte-enabled writes to word storage. After a fixed, parameterised latency it returns a one-cycle response carrying the read data. It also emits a one-cycle write-trace record per committed store, used by the grading log.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words stored.
LATENCY, 2, edges from request acceptance to memory operation; legal range 1..15.
BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
clk  input  1  clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_be  input  4  byte enables; bit i selects byte lane i (bits 8i+7:8i).
req_addr  input  32  byte address; bits [1:0] are ignored for indexing.
req_wdata  input  32  store data, already lane-aligned.
req_pc  input  32  PC of the requesting instruction.
resp_valid  output  1  one-cycle response strobe.
resp_rdata  output  32  word at the address after any write.
resp_err  output  1  address was out of range.
wlog_valid  output  1  one-cycle store-commit strobe.
wlog_pc  output  32  PC of the committed store.
wlog_addr  output  32  word-aligned byte address written ({addr[31:2],2'b00}).
wlog_data  output  32  full merged word after the write.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - req_ready = 1.
  - resp_valid, resp_err and wlog_valid = 0.
  - resp_rdata, wlog_pc, wlog_addr and wlog_data = 0.
  - All storage words = 0.
- FSM states:
  - IDLE: req_ready = 1. On an edge with req_valid & req_ready:
    - latch we, be, addr, wdata and pc;
    - cnt <= LATENCY-1;
    - go to WAIT.
  - WAIT: req_ready = 0.
    - If cnt != 0: cnt <= cnt-1.
    - If cnt == 0: perform the operation, load the response/trace registers, go to RESP.
  - RESP: req_ready = 0; resp_valid = 1 for exactly this cycle; next edge returns to IDLE.
- Timing:
  - Request accepted at edge k: memory operation at edge k+LATENCY; resp_valid high in the cycle after that edge.
  - Maximum throughput is one request per LATENCY+1 cycles.
  - Requests presented while req_ready = 0 are ignored; the initiator must hold them.
- Address range:
  - idx = (addr - BASE_ADDR) >> 2.
  - In range iff addr >= BASE_ADDR and idx < DEPTH_WORDS; the comparison is unsigned.
- Operation, in range:
  - Store: mem[idx] lane i <= wdata lane i for each set be[i]; other lanes unchanged.
  - resp_rdata = the merged word.
  - wlog_valid = 1 (same cycle as resp_valid) only if be != 0; wlog_pc/addr/data hold the latched pc, aligned address and merged word.
- Operation, out of range: no storage change; resp_rdata = 0; resp_err = 1; wlog_valid = 0.
- Load: resp_rdata = mem[idx]; req_be is ignored; no trace.
- Store with be = 4'b0000: no change, resp_rdata = current word, no trace.
- Output hold: resp_rdata and wlog_* hold their values until the next operation; the valid strobes are one cycle only.
- Reset mid-operation: the in-flight request is aborted.
  - No write occurs and no response is issued.
  - Storage is cleared; the FSM returns to IDLE.

Test Plan:
- Reset, then store addr=0x0000_0010, be=4'b1111, wdata=0xDEAD_BEEF, pc=0x3000, accepted edge 0 -> req_ready low for 3 cycles; resp_valid and wlog_valid high in the cycle after edge 2; wlog_addr=0x10, wlog_data=0xDEAD_BEEF, wlog_pc=0x3000.
- Then store addr=0x12, be=4'b1100, wdata=0x1234_0000 (sh) -> wlog_data=0x1234_BEEF; a following load from 0x10 -> resp_rdata=0x1234_BEEF, resp_err=0, no wlog.
- Store addr=0x13, be=4'b1000, wdata=0xAB00_0000 (sb), then load 0x10 -> resp_rdata=0xAB34_BEEF.
- Load addr=DEPTH_WORDS*4 (0x4000) -> resp_err=1, resp_rdata=0; store to same address -> resp_err=1, wlog_valid=0, storage unchanged.
- Store with be=0 to 0x10 -> resp_valid pulses, wlog_valid stays 0, word still 0xAB34_BEEF.
- Accept a store, assert reset on the next edge -> no resp_valid or wlog_valid ever follows; subsequent load of 0x10 returns 0; req_ready=1 in the cycle after reset.

Source files
------------

// File: rtl/dm_responder_if.sv
// Request / response / write-trace bundle between the Mem stage and dm_responder.
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        wlog_valid;
  logic [31:0] wlog_pc;
  logic [31:0] wlog_addr;
  logic [31:0] wlog_data;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           wlog_valid, wlog_pc, wlog_addr, wlog_data
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err,
           wlog_valid, wlog_pc, wlog_addr, wlog_data
  );
endinterface

// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder: fixed-latency byte-enabled load/store
// with a one-cycle response strobe and a store-commit trace record.
module dm_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  dm_responder_if.slave bus
);
  localparam int          NUM_LANES = 4;
  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  // Byte-offset limit: (off >> 2) < DEPTH  <=>  off < DEPTH*4
  localparam logic [31:0] LIMIT     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata, r_pc;
  logic        r_resp_valid, r_resp_err, r_wlog_valid;
  logic [31:0] r_resp_rdata, r_wlog_pc, r_wlog_addr, r_wlog_data;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_ready, w_accept, w_do_op;
  logic [31:0] w_off, w_old, w_merged;
  logic        w_in_range, w_commit;
  logic [IDX_W-1:0] w_idx;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_accept = 1'b0;
    w_do_op  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_do_op = 1'b1;
          w_next  = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_off      = r_addr - BASE_ADDR;
  assign w_in_range = (r_addr >= BASE_ADDR) && (w_off < LIMIT);
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_old      = r_mem[w_idx];
  assign w_commit   = w_in_range && r_we && (r_be != 4'b0000);

  // Loads see an all-zero effective enable, so the merge yields the stored word.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_merged[8*g +: 8] = (r_we && r_be[g]) ? r_wdata[8*g +: 8] : w_old[8*g +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_be         <= 4'b0000;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_pc         <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_wlog_valid <= 1'b0;
      r_wlog_pc    <= 32'd0;
      r_wlog_addr  <= 32'd0;
      r_wlog_data  <= 32'd0;
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'd0;
    end else begin
      r_resp_valid <= 1'b0;
      r_wlog_valid <= 1'b0;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_be    <= bus.req_be;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_pc    <= bus.req_pc;
        r_cnt   <= CNT_INIT;
      end
      if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_do_op) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= ~w_in_range;
        r_resp_rdata <= w_in_range ? w_merged : 32'd0;
        r_wlog_valid <= w_commit;
        if (w_commit) begin
          r_mem[w_idx] <= w_merged;
          r_wlog_pc    <= r_pc;
          r_wlog_addr  <= {r_addr[31:2], 2'b00};
          r_wlog_data  <= w_merged;
        end
      end
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.wlog_valid = r_wlog_valid;
  assign bus.wlog_pc    = r_wlog_pc;
  assign bus.wlog_addr  = r_wlog_addr;
  assign bus.wlog_data  = r_wlog_data;
endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: directed plan plus randomized traffic against a
// sparse-array memory model.
module tb_dm_responder;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dm_responder_if bus();
  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        wlog;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [int];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: word-addressed sparse memory, byte lanes updated individually.
  task automatic model(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc, output exp_t e);
    longint      a, b;
    bit          inr;
    int          k;
    logic [31:0] word;
    a = longint'(addr);
    b = longint'(BASE);
    inr = (a >= b) && (((a - b) / 4) < DEPTH);
    k = inr ? int'((a - b) / 4) : -1;
    word = (inr && mdl.exists(k)) ? mdl[k] : 32'd0;
    if (inr && we && be != 4'b0000) begin
      for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
      mdl[k] = word;
    end
    e.rdata = inr ? word : 32'd0;
    e.err   = !inr;
    e.wlog  = inr && we && (be != 4'b0000);
    e.pc    = pc;
    e.addr  = {addr[31:2], 2'b00};
    e.data  = word;
    e.acc   = 0;
  endtask

  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc, input bit exp_resp);
    logic rdy;
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_pc    = pc;
    forever begin
      rdy = bus.req_ready;
      @(posedge clk);
      if (rdy) break;
      t++;
      if (t > 100) begin
        flag("req_ready_timeout");
        bus.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    model(we, be, addr, wdata, pc, e);
    e.acc = cyc;
    if (exp_resp) sbq.push_back(e);
  endtask

  // Monitor: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.resp_valid) begin
        if (sbq.size() == 0) flag("unexpected_resp");
        else begin
          e = sbq.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", 32'(bus.resp_err), 32'(e.err));
          chk("wlog_valid", 32'(bus.wlog_valid), 32'(e.wlog));
          chk("latency", 32'(cyc - e.acc), 32'(LAT));
          if (e.wlog) begin
            chk("wlog_pc", bus.wlog_pc, e.pc);
            chk("wlog_addr", bus.wlog_addr, e.addr);
            chk("wlog_data", bus.wlog_data, e.data);
          end
        end
      end else if (bus.wlog_valid) flag("stray_wlog_valid");
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() > 0) begin
      flag("resp_timeout");
      sbq.delete();
    end
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_be    = 4'b0000;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_pc    = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_wlog_valid", 32'(bus.wlog_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_wlog_pc", bus.wlog_pc, 32'd0);
    chk("rst_wlog_addr", bus.wlog_addr, 32'd0);
    chk("rst_wlog_data", bus.wlog_data, 32'd0);

    issue(1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF, 32'h3000, 1'b1);
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      chk("ready_busy", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    chk("ready_back", 32'(bus.req_ready), 32'd1);

    issue(1'b1, 4'b1100, 32'h12, 32'h1234_0000, 32'h3004, 1'b1);
    issue(1'b0, 4'b1111, 32'h10, 32'h0, 32'h3008, 1'b1);
    issue(1'b1, 4'b1000, 32'h13, 32'hAB00_0000, 32'h300C, 1'b1);
    issue(1'b0, 4'b0000, 32'h10, 32'h0, 32'h3010, 1'b1);
    issue(1'b0, 4'b0000, 32'h4000, 32'h0, 32'h3014, 1'b1);
    issue(1'b1, 4'b1111, 32'h4000, 32'hFFFF_FFFF, 32'h3018, 1'b1);
    issue(1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, 32'h301C, 1'b1);
    issue(1'b0, 4'b0000, 32'h10, 32'h0, 32'h3020, 1'b1);
    issue(1'b1, 4'b1111, 32'h3FFC, 32'h0BAD_F00D, 32'h3024, 1'b1);
    issue(1'b0, 4'b0000, 32'h3FFE, 32'h0, 32'h3028, 1'b1);
    drain();

    // Abort an in-flight store with reset on the edge after acceptance.
    issue(1'b1, 4'b1111, 32'h10, 32'h5555_AAAA, 32'h4000, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
    mdl.delete();
    sbq.delete();
    repeat (LAT + 3) @(negedge clk);
    issue(1'b0, 4'b0000, 32'h10, 32'h0, 32'h4004, 1'b1);
    issue(1'b0, 4'b0000, 32'h3FFC, 32'h0, 32'h4008, 1'b1);
    drain();

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(7, 0));
      if (r < 6)       a = BASE + 32'($urandom_range(15, 0) * 4) + 32'($urandom_range(3, 0));
      else if (r == 6) a = BASE + 32'h3FF0 + 32'($urandom_range(31, 0));
      else             a = $urandom;
      issue(1'($urandom), 4'($urandom), a, $urandom, $urandom, 1'b1);
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(4, 1)) @(negedge clk);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
